gbuff_out_streamer: RTL

GBUFF_OUT_STREAMER -- requirements
Module: gbuff_out_streamer

---
 rtl/gbuff_out_streamer_pkg.sv | 21 ++
 rtl/gbuff_out_streamer_if.sv | 32 +++
 rtl/gbuff_out_streamer_out_mask_gen.sv | 25 ++
 rtl/gbuff_out_streamer.sv | 112 +++++++++++
 4 files changed

// File: rtl/gbuff_out_streamer_pkg.sv
// Shared TPU constants for the output-buffer streamer: word size, buffer depth, byte width, FSM encoding.
package gbuff_out_streamer_pkg;

  localparam int GBUFF_WORD_W = 256;
  localparam int GBUFF_DEPTH  = 32;
  localparam int BYTE_W       = 8;
  localparam int ADDR_W       = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Byte 0 sits in the most significant bits of a row.
  function automatic int byte_msb(input int col, input int word_w);
    return word_w - 1 - col * BYTE_W;
  endfunction

endpackage

// File: rtl/gbuff_out_streamer_if.sv
// Bus bundle between the array controller / output SRAM / host and the result streamer.
interface gbuff_out_streamer_if
  import gbuff_out_streamer_pkg::*;
#(
  parameter int WORD_W = GBUFF_WORD_W
);
  logic              start;
  logic [4:0]        m;
  logic [4:0]        n;
  logic              rd_en;
  logic [4:0]        rd_addr;
  logic [WORD_W-1:0] rd_data;
  logic [WORD_W-1:0] gbuff_out;
  logic              out_valid;
  logic              busy;
  logic              done;
  state_t            state_dbg;
  logic [4:0]        m_lat_dbg;
  logic [4:0]        n_lat_dbg;

  // Handshake: start is a one-cycle request honoured only when busy=0 and done=0; rd_data must
  // follow rd_en by exactly one cycle; out_valid has no ready, the host takes every valid row.
  modport master (
    input  start, m, n, rd_data,
    output rd_en, rd_addr, gbuff_out, out_valid, busy, done, state_dbg, m_lat_dbg, n_lat_dbg
  );

  modport slave (
    output start, m, n, rd_data,
    input  rd_en, rd_addr, gbuff_out, out_valid, busy, done, state_dbg, m_lat_dbg, n_lat_dbg
  );
endinterface

// File: rtl/gbuff_out_streamer_out_mask_gen.sv
// Combinational byte mask: zeroes rows past the last valid row and byte columns past the last valid column.
module out_mask_gen
  import gbuff_out_streamer_pkg::*;
#(
  parameter int WORD_W = GBUFF_WORD_W
) (
  input  logic [4:0]        row,
  input  logic [4:0]        m,
  input  logic [4:0]        n,
  input  logic [WORD_W-1:0] data,
  output logic [WORD_W-1:0] data_out
);

  localparam int NUM_BYTES = WORD_W / BYTE_W;

  always_comb begin
    data_out = data;
    for (int c = 0; c < NUM_BYTES; c++) begin
      if ((row > m) || (c > int'(n))) begin
        data_out[byte_msb(c, WORD_W) -: BYTE_W] = '0;
      end
    end
  end

endmodule

// File: rtl/gbuff_out_streamer.sv
// Streams DEPTH rows from the output global buffer to the host; byte masking is enabled by OUT_MASK_EN.
module gbuff_out_streamer
  import gbuff_out_streamer_pkg::*;
#(
  parameter int WORD_W = GBUFF_WORD_W,
  parameter int DEPTH  = GBUFF_DEPTH
) (
  input logic                   clk,
  input logic                   rst,
  gbuff_out_streamer_if.master  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              rd_en_r;
  logic              busy_r;
  logic              done_r;
  logic [4:0]        m_lat;
  logic [4:0]        n_lat;
  logic              rd_en_q;
  logic              out_valid_r;
  logic [WORD_W-1:0] gbuff_out_r;
  logic [WORD_W-1:0] row_data;

  // done is registered off FIN, so it lands in the cycle after the last valid row; the !done
  // term keeps a start issued alongside done from being taken as a new job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_en_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      m_lat   <= '0;
      n_lat   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !done_r) begin
            m_lat   <= bus.m;
            n_lat   <= bus.n;
            cnt     <= '0;
            rd_en_r <= 1'b1;
            busy_r  <= 1'b1;
            state   <= READ;
          end
        end
        READ: begin
          if (cnt == LAST_ADDR) begin
            rd_en_r <= 1'b0;
            state   <= DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: state <= FIN;
        FIN: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OUT_MASK_EN
  logic [ADDR_W-1:0] row_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) row_q <= '0;
    else     row_q <= cnt;
  end

  out_mask_gen #(.WORD_W(WORD_W)) u_mask (
    .row      (row_q),
    .m        (m_lat),
    .n        (n_lat),
    .data     (bus.rd_data),
    .data_out (row_data)
  );
`else
  assign row_data = bus.rd_data;
`endif

  // rd_en is delayed twice so out_valid lines up with the registered copy of rd_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en_q     <= 1'b0;
      out_valid_r <= 1'b0;
      gbuff_out_r <= '0;
    end else begin
      rd_en_q     <= rd_en_r;
      out_valid_r <= rd_en_q;
      if (rd_en_q) gbuff_out_r <= row_data;
    end
  end

  assign bus.rd_en     = rd_en_r;
  assign bus.rd_addr   = cnt;
  assign bus.gbuff_out = gbuff_out_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.state_dbg = state;
  assign bus.m_lat_dbg = m_lat;
  assign bus.n_lat_dbg = n_lat;

endmodule
